// File: rtl/ram_access_arbiter_if.sv
// Bundles the two requester handshakes, the clear command and the RAM control pins
// between the arbiter (slave) and its environment (master).
interface ram_access_arbiter_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
);
  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;
  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;
  logic [DATA_W-1:0] rdata;
  logic              clr_req;
  logic              clr_ack;
  logic              busy;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_we;
  logic              ram_rst;
  logic [DATA_W-1:0] ram_dout;

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, clr_req, ram_dout,
    input  ack0, ack1, rdata, clr_ack, busy, ram_addr, ram_din, ram_we, ram_rst
  );

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, clr_req, ram_dout,
    output ack0, ack1, rdata, clr_ack, busy, ram_addr, ram_din, ram_we, ram_rst
  );
endinterface

// File: rtl/ram_access_arbiter.sv
// Arbitrates a single-port registered 16x8 RAM between two requesters and a clear-all
// command; every output comes straight from a flop.
module ram_access_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input logic                 clk,
  input logic                 reset,
  ram_access_arbiter_if.slave bus
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] CLEAR   = 3'd1;
  localparam logic [2:0] ACCESS  = 3'd2;
  localparam logic [2:0] CAPTURE = 3'd3;
  localparam logic [2:0] DONE    = 3'd4;

  logic [2:0]        state,     state_nxt;
  logic              sel,       sel_nxt;
  logic              rr_last,   rr_nxt;
  logic              ack0_q,    ack0_nxt;
  logic              ack1_q,    ack1_nxt;
  logic              clr_ack_q, clr_ack_nxt;
  logic              busy_q,    busy_nxt;
  logic              we_q,      we_nxt;
  logic              rst_q,     rst_nxt;
  logic [ADDR_W-1:0] addr_q,    addr_nxt;
  logic [DATA_W-1:0] din_q,     din_nxt;
  logic [DATA_W-1:0] rdata_q,   rdata_nxt;
  logic              pick1;

  // Next-state and next-output decode
  always_comb begin
    state_nxt   = state;
    sel_nxt     = sel;
    rr_nxt      = rr_last;
    ack0_nxt    = ack0_q;
    ack1_nxt    = ack1_q;
    clr_ack_nxt = clr_ack_q;
    we_nxt      = we_q;
    rst_nxt     = rst_q;
    addr_nxt    = addr_q;
    din_nxt     = din_q;
    rdata_nxt   = rdata_q;
    // On a tie the port that did not win last time is served
    pick1       = bus.req1 && (!bus.req0 || !rr_last);

    case (state)
      IDLE: begin
        if (bus.clr_req) begin
          rst_nxt   = 1'b1;
          state_nxt = CLEAR;
        end else if (bus.req0 || bus.req1) begin
          sel_nxt   = pick1;
          rr_nxt    = pick1;
          addr_nxt  = pick1 ? bus.addr1  : bus.addr0;
          din_nxt   = pick1 ? bus.wdata1 : bus.wdata0;
          we_nxt    = pick1 ? bus.we1    : bus.we0;
          state_nxt = ACCESS;
        end
      end
      CLEAR: begin
        rst_nxt     = 1'b0;
        clr_ack_nxt = 1'b1;
        state_nxt   = DONE;
      end
      ACCESS: begin
        // we_q still reflects the granted direction during this cycle
        we_nxt = 1'b0;
        if (we_q) begin
          if (sel) ack1_nxt = 1'b1;
          else     ack0_nxt = 1'b1;
          state_nxt = DONE;
        end else begin
          state_nxt = CAPTURE;
        end
      end
      CAPTURE: begin
        rdata_nxt = bus.ram_dout;
        if (sel) ack1_nxt = 1'b1;
        else     ack0_nxt = 1'b1;
        state_nxt = DONE;
      end
      DONE: begin
        ack0_nxt    = 1'b0;
        ack1_nxt    = 1'b0;
        clr_ack_nxt = 1'b0;
        state_nxt   = IDLE;
      end
      default: begin
        ack0_nxt    = 1'b0;
        ack1_nxt    = 1'b0;
        clr_ack_nxt = 1'b0;
        we_nxt      = 1'b0;
        rst_nxt     = 1'b0;
        state_nxt   = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      sel       <= 1'b0;
      rr_last   <= 1'b1;
      ack0_q    <= 1'b0;
      ack1_q    <= 1'b0;
      clr_ack_q <= 1'b0;
      busy_q    <= 1'b0;
      we_q      <= 1'b0;
      rst_q     <= 1'b0;
      addr_q    <= '0;
      din_q     <= '0;
      rdata_q   <= '0;
    end else begin
      state     <= state_nxt;
      sel       <= sel_nxt;
      rr_last   <= rr_nxt;
      ack0_q    <= ack0_nxt;
      ack1_q    <= ack1_nxt;
      clr_ack_q <= clr_ack_nxt;
      busy_q    <= busy_nxt;
      we_q      <= we_nxt;
      rst_q     <= rst_nxt;
      addr_q    <= addr_nxt;
      din_q     <= din_nxt;
      rdata_q   <= rdata_nxt;
    end
  end

  assign bus.ack0     = ack0_q;
  assign bus.ack1     = ack1_q;
  assign bus.clr_ack  = clr_ack_q;
  assign bus.busy     = busy_q;
  assign bus.ram_we   = we_q;
  assign bus.ram_rst  = rst_q;
  assign bus.ram_addr = addr_q;
  assign bus.ram_din  = din_q;
  assign bus.rdata    = rdata_q;

endmodule

// File: tb/tb_ram_access_arbiter.sv
// Randomized bench for ram_access_arbiter: a behavioural RAM on the pins plus a
// transaction-level memory/round-robin model that predicts data, order and latency.
module tb_ram_access_arbiter;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DATA_W = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  ram_access_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_access_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Registered single-port RAM attached to the arbiter's pins
  logic [DATA_W-1:0] ram [16];
  always @(posedge clk) begin
    if (bus.ram_rst) begin
      for (int i = 0; i < 16; i++) ram[i] <= '0;
    end else if (bus.ram_we) begin
      ram[bus.ram_addr] <= bus.ram_din;
    end
    bus.ram_dout <= ram[bus.ram_addr];
  end

  logic [DATA_W-1:0] model [16];
  logic [DATA_W-1:0] exp_rdata;
  int                rr_model;
  int                order_q[$];
  int                checks = 0;
  int                errors = 0;
  int                acnt0 = 0, acnt1 = 0;
  logic              prev_ack0 = 1'b0, prev_ack1 = 1'b0, prev_clr = 1'b0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  // Protocol invariants and ack counting, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      check("we_rst_excl", 32'(bus.ram_we & bus.ram_rst), 0);
      check("ack_width", 32'((bus.ack0 & prev_ack0) | (bus.ack1 & prev_ack1) |
                             (bus.clr_ack & prev_clr)), 0);
      acnt0 += int'(bus.ack0);
      acnt1 += int'(bus.ack1);
    end
    prev_ack0 = bus.ack0;
    prev_ack1 = bus.ack1;
    prev_clr  = bus.clr_ack;
  end

  task automatic drive(input int p, input logic req, input logic we,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (p == 0) begin
      bus.req0 = req; bus.we0 = we; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = req; bus.we1 = we; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  // Completion bookkeeping shared by all access paths
  task automatic complete(input int p, input logic we,
                          input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (we) model[a] = d;
    else    exp_rdata = model[a];
    check("rdata", 32'(bus.rdata), 32'(exp_rdata));
    check("busy_in_ack", 32'(bus.busy), 1);
    rr_model = p;
  endtask

  // One access from an idle arbiter with no competing request
  task automatic do_single(input int p, input logic we,
                           input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int cyc = 0, we_cyc = 0, other0;
    logic seen = 1'b0;
    other0 = (p == 0) ? acnt1 : acnt0;
    drive(p, 1'b1, we, a, d);
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.ram_we) we_cyc++;
      seen = (p == 0) ? bus.ack0 : bus.ack1;
    end
    check("ack_seen", 32'(seen), 1);
    check("latency", cyc, we ? 2 : 3);
    check("we_pulse", we_cyc, we ? 1 : 0);
    complete(p, we, a, d);
    drive(p, 1'b0, 1'b0, a, d);
    @(posedge clk); #1;
    check("busy_idle", 32'(bus.busy), 0);
    check("other_ack", (p == 0) ? acnt1 : acnt0, other0);
  endtask

  task automatic do_clear();
    int cyc = 0, rst_cyc = 0;
    logic seen = 1'b0;
    bus.clr_req = 1'b1;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      if (bus.ram_rst) rst_cyc++;
      seen = bus.clr_ack;
    end
    check("clr_seen", 32'(seen), 1);
    check("clr_latency", cyc, 2);
    check("rst_pulse", rst_cyc, 1);
    for (int i = 0; i < 16; i++) model[i] = '0;
    check("rdata_hold_clr", 32'(bus.rdata), 32'(exp_rdata));
    bus.clr_req = 1'b0;
    @(posedge clk); #1;
    check("busy_idle_clr", 32'(bus.busy), 0);
  endtask

  // A requester that holds req high across n back-to-back accesses
  task automatic requester(input int p, input int n, input logic wr_en);
    logic we;
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic seen;
    int cyc;
    for (int k = 0; k < n; k++) begin
      we = wr_en & 1'($urandom_range(0, 1));
      a  = ADDR_W'($urandom_range(0, 15));
      d  = DATA_W'($urandom);
      drive(p, 1'b1, we, a, d);
      seen = 1'b0;
      cyc  = 0;
      while (!seen && cyc < 40) begin
        @(posedge clk); #1;
        cyc++;
        seen = (p == 0) ? bus.ack0 : bus.ack1;
      end
      check("pair_ack_seen", 32'(seen), 1);
      if (!seen) break;
      complete(p, we, a, d);
      order_q.push_back(p);
    end
    drive(p, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic run_pair(input int n, input logic wr_en);
    int first;
    first = (rr_model == 1) ? 0 : 1;
    order_q.delete();
    fork
      requester(0, n, wr_en);
      requester(1, n, wr_en);
    join
    @(posedge clk); #1;
    check("pair_count", order_q.size(), 2 * n);
    foreach (order_q[i]) check("rr_order", order_q[i], (first + i) % 2);
  endtask

  initial begin
    int cyc;
    logic seen;
    int a0;

    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    bus.clr_req = 1'b0;
    exp_rdata = '0;
    rr_model = 1;
    for (int i = 0; i < 16; i++) model[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_acks", 32'({bus.ack0, bus.ack1, bus.clr_ack}), 0);
    check("rst_ram_ctl", 32'({bus.ram_we, bus.ram_rst}), 0);
    check("rst_ram_addr", 32'(bus.ram_addr), 0);
    check("rst_ram_din", 32'(bus.ram_din), 0);
    check("rst_rdata", 32'(bus.rdata), 0);
    reset = 1'b1;

    // Known memory contents before anything else
    do_clear();

    // Simultaneous reads: port 0 first, then strict alternation
    run_pair(4, 1'b0);

    // Basic write then read-back on port 0
    do_single(0, 1'b1, 4'd3, 8'hA5);
    do_single(0, 1'b0, 4'd3, 8'h00);

    // Address extremes and rdata holding across a write
    do_single(1, 1'b1, 4'd15, 8'hFF);
    do_single(0, 1'b0, 4'd0, 8'h00);
    do_single(1, 1'b0, 4'd15, 8'h00);
    do_single(0, 1'b1, 4'd8, 8'h3C);

    // Fill memory, then clear and a read raised together: clear wins
    for (int i = 0; i < 16; i++) do_single(i % 2, 1'b1, ADDR_W'(i), 8'h5A);
    bus.clr_req = 1'b1;
    drive(0, 1'b1, 1'b0, 4'd0, 8'h00);
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1; cyc++; seen = bus.clr_ack;
    end
    check("clr_first_seen", 32'(seen), 1);
    check("clr_first_lat", cyc, 2);
    check("clr_first_noack", 32'(bus.ack0), 0);
    for (int i = 0; i < 16; i++) model[i] = '0;
    bus.clr_req = 1'b0;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk); #1; cyc++; seen = bus.ack0;
    end
    check("after_clr_seen", 32'(seen), 1);
    check("after_clr_lat", cyc, 4);
    complete(0, 1'b0, 4'd0, 8'h00);
    drive(0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    for (int i = 1; i < 16; i++) do_single(i % 2, 1'b0, ADDR_W'(i), 8'h00);

    // Reset while the read is in its capture cycle
    do_single(0, 1'b1, 4'd7, 8'hC3);
    a0 = acnt0;
    drive(0, 1'b1, 1'b0, 4'd7, 8'h00);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    @(posedge clk); #1;
    check("abort_acks", 32'({bus.ack0, bus.ack1, bus.clr_ack}), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_ram_ctl", 32'({bus.ram_we, bus.ram_rst}), 0);
    check("abort_ram_addr", 32'(bus.ram_addr), 0);
    check("abort_ram_din", 32'(bus.ram_din), 0);
    check("abort_rdata", 32'(bus.rdata), 0);
    reset = 1'b1;
    exp_rdata = '0;
    rr_model = 1;
    check("abort_no_ack", acnt0, a0);
    do_single(0, 1'b0, 4'd7, 8'h00);

    // Randomized mix of single accesses, contended bursts and clears
    for (int k = 0; k < 40; k++) begin
      case ($urandom_range(0, 9))
        0:       do_clear();
        1, 2:    run_pair(int'($urandom_range(1, 3)), 1'b1);
        default: do_single(int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/ram_access_arbiter.md
Name: ram_access_arbiter

Overview:
- Shares the single-port 16x8 RAM between two requesters: port 0 (CPU) and port 1 (program loader/IO), plus a whole-memory clear command.
- Sequences each access to the RAM's registered timing: write commits at the next clock edge; read data appears one edge after the address is presented.
- Owns all RAM control pins (address, data in, write enable, clear) and returns read data with a one-cycle acknowledge per requester.

Parameters:
- ADDR_W, 4, RAM address width (16 words)
- DATA_W, 8, RAM data width

Ports:
- clk  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- req0  in  1  port 0 access request; held high until ack0
- we0  in  1  port 0: 1=write, 0=read; stable while req0 high
- addr0  in  ADDR_W  port 0 address; stable while req0 high
- wdata0  in  DATA_W  port 0 write data; stable while req0 high
- ack0  out  1  one-cycle completion pulse for port 0
- req1, we1, addr1, wdata1, ack1  same as port 0, for port 1
- rdata  out  DATA_W  read result; valid in the ack cycle of a read
- clr_req  in  1  request to zero all RAM words; held until clr_ack
- clr_ack  out  1  one-cycle completion pulse for clear
- busy  out  1  high in every state except IDLE
- ram_addr  out  ADDR_W  to RAM address
- ram_din  out  DATA_W  to RAM data_in
- ram_we  out  1  to RAM write_enable
- ram_rst  out  1  to RAM reset (active-high clear-all)
- ram_dout  in  DATA_W  from RAM data_out

Behaviour:
- Reset (reset=0 at an edge): state=IDLE; ack0, ack1, clr_ack, busy, ram_we, ram_rst=0; ram_addr, ram_din, rdata=0; rr_last=1 so port 0 wins the first tie. RAM contents are not cleared by reset.
- All outputs are registered.
- States and transitions:
  - IDLE: priority is clr_req > round-robin between req0 and req1.
    - clr_req -> CLEAR, ram_rst<=1.
    - Otherwise a granted port p: latch p; ram_addr<=addr_p; ram_din<=wdata_p; ram_we<=we_p; -> ACCESS.
    - No request -> stay in IDLE.
  - CLEAR (1 cycle): the RAM zeroes all 16 words at this edge. ram_rst<=0; clr_ack<=1; -> DONE.
  - ACCESS (1 cycle): the RAM writes or captures the read at this edge. ram_we<=0.
    - Write -> DONE with ack_p<=1.
    - Read -> CAPTURE.
  - CAPTURE (1 cycle): rdata<=ram_dout; ack_p<=1; -> DONE.
  - DONE (1 cycle): the ack is visible this cycle. All acks<=0; -> IDLE. The requester drops req at this same edge. Requests are not sampled in DONE.
- Latency, counted from the IDLE edge that grants the request:
  - write: ack high after edge +1
  - read: ack and rdata high after edge +2
  - clear: clr_ack high after edge +1
  - Back-to-back accesses issue at most one every 3 cycles for writes and 4 for reads.
- Round-robin:
  - rr_last updates to p on each grant.
  - With both req0 and req1 high, grant the port != rr_last.
  - A single request is granted immediately, regardless of rr_last.
- rdata holds its value until the next read capture. It is unchanged by writes and clears.
- ram_addr and ram_din hold their last values after an access. ram_we and ram_rst are never high in the same cycle.
- Reset mid-operation: forces IDLE and no ack is issued. A write whose ram_we was already high at the reset edge still commits in the RAM. An abort in CLEAR likewise still clears.
- Requests whose req is high without an ack are never dropped. A losing port stays pending and wins next arbitration.

Test Plan:
- Port 0 write addr=3 data=0xA5, then port 0 read addr=3 -> ram_we high exactly one cycle; ack0 2 cycles after req sampled; read ack0 with rdata=0xA5 3 cycles after grant; ack1 never pulses.
- req0 and req1 asserted in the same cycle after reset, both reads -> port 0 served first, then port 1; with both held continuously, grants alternate 0,1,0,1.
- clr_req and req0 asserted together after writing 0x5A to all 16 addresses -> ram_rst pulses one cycle and clr_ack pulses; port 0 is then served, and reads of addresses 0..15 return 0x00.
- reset=0 asserted while in CAPTURE of a read -> no ack, busy=0 and all outputs 0 next cycle; previously written data is intact on subsequent read.
- Write addr=15 data=0xFF, then read addr=0 -> no address wrap issues; rdata=0x00 for addr 0 and 0xFF for a read of addr 15; rdata holds 0xFF through a following write.
